// File: rtl/ov7670_cfg_pkg.sv
// ov7670_cfg_pkg: shared types and constants for the OV7670 SCCB configurator.
// Holds the FSM state enum, table markers and sensor register addresses.
package ov7670_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    BITS,
    STOP,
    GAP,
    DELAY,
    DONE
  } state_t;

  localparam logic [15:0] TBL_END   = 16'hFFFF;
  localparam logic [15:0] TBL_DELAY = 16'hFFF0;

  localparam logic [7:0] COM7   = 8'h12;
  localparam logic [7:0] RGB444 = 8'h8C;
  localparam logic [7:0] COM15  = 8'h40;
  localparam logic [7:0] CLKRC  = 8'h11;

  // Slots 8, 17 and 26 are the ninth (ACK / don't-care) bit of each phase.
  function automatic logic dc_slot(input logic [4:0] s);
    return (s == 5'd8) || (s == 5'd17) || (s == 5'd26);
  endfunction

endpackage

// File: rtl/ov7670_reg_rom.sv
// ov7670_reg_rom: index -> {reg, val} lookup of the OV7670 power-up table.
// Ports: idx (table index), entry (16-bit entry). Macro OV7670_TEST_PATTERN_EN.
module ov7670_reg_rom
  import ov7670_cfg_pkg::*;
(
  input  logic [7:0]  idx,
  output logic [15:0] entry
);

  always_comb begin
    entry = TBL_END;
    case (idx)
      8'd0:  entry = {COM7, 8'h80};
      8'd1:  entry = TBL_DELAY;
      8'd2:  entry = {COM7, 8'h04};
      8'd3:  entry = {COM15, 8'hD0};
      8'd4:  entry = {RGB444, 8'h00};
      8'd5:  entry = {CLKRC, 8'h00};
      8'd6:  entry = 16'h0C00;
      8'd7:  entry = 16'h3E00;
      8'd8:  entry = 16'h3A04;
      8'd9:  entry = 16'h1713;
      8'd10: entry = 16'h1801;
      8'd11: entry = 16'h32B6;
      8'd12: entry = 16'h1902;
      8'd13: entry = 16'h1A7A;
      8'd14: entry = 16'h030A;
`ifdef OV7670_TEST_PATTERN_EN
      // 8-bar colour test pattern for bring-up without optics.
      8'd15: entry = 16'h703A;
      8'd16: entry = 16'h71B5;
`endif
      default: entry = TBL_END;
    endcase
  end

endmodule

// File: rtl/ov7670_sccb_config.sv
// ov7670_sccb_config: walks the register table, one SCCB 3-phase write each.
// Ports: clk, rst, start -> busy, done, reg_idx, sioc, siod_o, siod_oe.
// Optional table extension under OV7670_TEST_PATTERN_EN (see ov7670_reg_rom).
module ov7670_sccb_config
  import ov7670_cfg_pkg::*;
#(
  parameter int          CLK_HZ       = 25_000_000,
  parameter int          SCCB_HZ      = 100_000,
  parameter logic [7:0]  DEV_ID       = 8'h42,
  parameter int          DELAY_CYCLES = 250_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [7:0] reg_idx,
  output logic       sioc,
  output logic       siod_o,
  output logic       siod_oe
);

  localparam int QDIV = CLK_HZ / (4 * SCCB_HZ);
  localparam int QW = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam int DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

  if (QDIV < 1) begin : g_qdiv_chk
    $error("ov7670_sccb_config: CLK_HZ/(4*SCCB_HZ) must be >= 1");
  end

  state_t         state;
  logic [QW-1:0]  qcnt;
  logic           qtick;
  logic [1:0]     q;
  logic [4:0]     slot;
  logic [26:0]    sr;
  logic [DW-1:0]  dcnt;
  logic [15:0]    entry;

  ov7670_reg_rom u_rom (
    .idx   (reg_idx),
    .entry (entry)
  );

  assign qtick = (qcnt == QW'(QDIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      qcnt    <= '0;
      q       <= '0;
      slot    <= '0;
      sr      <= '0;
      dcnt    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      reg_idx <= '0;
      sioc    <= 1'b1;
      siod_o  <= 1'b1;
      siod_oe <= 1'b1;
    end else begin
      qcnt <= qtick ? '0 : qcnt + 1'b1;
      unique case (state)
        IDLE: begin
          qcnt <= '0;
          if (start) begin
            state   <= FETCH;
            busy    <= 1'b1;
            done    <= 1'b0;
            reg_idx <= '0;
          end
        end
        FETCH: begin
          qcnt <= '0;
          q    <= '0;
          slot <= '0;
          dcnt <= '0;
          unique case (1'b1)
            (entry == TBL_END): begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
            (entry == TBL_DELAY): state <= DELAY;
            default: begin
              state   <= START;
              sr      <= {DEV_ID, 1'b1, entry[15:8], 1'b1, entry[7:0], 1'b1};
              sioc    <= 1'b1;
              siod_o  <= 1'b0;
              siod_oe <= 1'b1;
            end
          endcase
        end
        START: begin
          if (qtick) begin
            if (q == 2'd0) begin
              q    <= 2'd1;
              sioc <= 1'b0;
            end else begin
              state   <= BITS;
              q       <= '0;
              slot    <= '0;
              siod_o  <= sr[26];
              sr      <= {sr[25:0], 1'b0};
              siod_oe <= 1'b1;
            end
          end
        end
        BITS: begin
          if (qtick) begin
            if (q == 2'd1) sioc <= 1'b1;
            if (q != 2'd3) begin
              q <= q + 2'd1;
            end else if (slot == 5'd26) begin
              state   <= STOP;
              q       <= '0;
              sioc    <= 1'b0;
              siod_o  <= 1'b0;
              siod_oe <= 1'b1;
            end else begin
              q       <= '0;
              slot    <= slot + 5'd1;
              sioc    <= 1'b0;
              siod_o  <= sr[26];
              sr      <= {sr[25:0], 1'b0};
              siod_oe <= !dc_slot(slot + 5'd1);
            end
          end
        end
        STOP: begin
          if (qtick) begin
            q <= q + 2'd1;
            if (q == 2'd0) sioc <= 1'b1;
            if (q == 2'd1) siod_o <= 1'b1;
            if (q == 2'd2) begin
              state <= GAP;
              q     <= '0;
            end
          end
        end
        GAP: begin
          if (qtick) begin
            q <= q + 2'd1;
            if (q == 2'd3) begin
              state   <= FETCH;
              reg_idx <= reg_idx + 8'd1;
            end
          end
        end
        DELAY: begin
          qcnt <= '0;
          dcnt <= dcnt + 1'b1;
          if (dcnt == DW'(DELAY_CYCLES - 1)) begin
            state   <= FETCH;
            reg_idx <= reg_idx + 8'd1;
          end
        end
        DONE: begin
          qcnt  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// tb_ov7670_sccb_config: directed bench with an SCCB bus decoder and scoreboard.
// Decoded writes are popped against the expected table pushed at each start.
module tb_ov7670_sccb_config;

`ifdef OV7670_TEST_PATTERN_EN
  localparam int END_IDX = 17;
`else
  localparam int END_IDX = 15;
`endif

  logic       clk;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] reg_idx;
  logic       sioc;
  logic       siod_o;
  logic       siod_oe;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic        p_sioc = 1'b1;
  logic        p_siod = 1'b1;
  logic        in_frame = 1'b0;
  logic [26:0] shreg;
  int          nbits = 0;
  int          run = 0;
  int          sioc_edges = 0;
  int          frames_started = 0;
  int          frames_done = 0;
  int          stops = 0;
  logic [15:0] last_rv = '0;

  ov7670_sccb_config #(
    .CLK_HZ       (400_000),
    .SCCB_HZ      (100_000),
    .DEV_ID       (8'h42),
    .DELAY_CYCLES (20)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .reg_idx (reg_idx),
    .sioc    (sioc),
    .siod_o  (siod_o),
    .siod_oe (siod_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] tbl(input int i);
    case (i)
      0:  return 16'h1280;
      1:  return 16'hFFF0;
      2:  return 16'h1204;
      3:  return 16'h40D0;
      4:  return 16'h8C00;
      5:  return 16'h1100;
      6:  return 16'h0C00;
      7:  return 16'h3E00;
      8:  return 16'h3A04;
      9:  return 16'h1713;
      10: return 16'h1801;
      11: return 16'h32B6;
      12: return 16'h1902;
      13: return 16'h1A7A;
      14: return 16'h030A;
`ifdef OV7670_TEST_PATTERN_EN
      15: return 16'h703A;
      16: return 16'h71B5;
`endif
      default: return 16'hFFFF;
    endcase
  endfunction

  task automatic push_tbl();
    for (int i = 0; i < END_IDX; i++)
      if (tbl(i) != 16'hFFF0) exp_q.push_back(tbl(i));
  endtask

  // Bus decoder, sampled on the falling clock edge.
  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
    end else begin
      if (sioc !== p_sioc) begin
        sioc_edges++;
        run = 0;
      end else begin
        run++;
      end
      if (p_sioc && sioc && p_siod && !siod_o) begin
        frames_started++;
        if (frames_started == 2) chk("gap_after_delay", 32'(run), 32'd28);
        if (frames_started == 3) chk("gap_normal", 32'(run), 32'd7);
        in_frame = 1'b1;
        nbits = 0;
      end
      if (in_frame && !p_sioc && sioc) begin
        if (nbits == 8 || nbits == 17 || nbits == 26)
          chk("dc_slot_oe", 32'(siod_oe), 32'd0);
        shreg = {shreg[25:0], siod_o};
        nbits++;
        if (nbits == 27) begin
          in_frame = 1'b0;
          frames_done++;
          last_rv = {shreg[17:10], shreg[8:1]};
          chk("dev_id", 32'(shreg[26:19]), 32'h42);
          if (exp_q.size() == 0) begin
            chk("sb_unexpected_write", 32'(last_rv), 32'hFFFF);
          end else begin
            chk("write_reg_val", 32'(last_rv), 32'(exp_q.pop_front()));
          end
        end
      end
      if (!in_frame && p_sioc && sioc && !p_siod && siod_o) stops++;
    end
    p_sioc = sioc;
    p_siod = siod_o;
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_bits(input int b, input string tag);
    int n = 0;
    while (!(in_frame && nbits == b) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, 32'(nbits), 32'(b));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_sioc", 32'(sioc), 32'd1);
    chk("rst_siod", 32'(siod_o), 32'd1);
    chk("rst_oe", 32'(siod_oe), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_idx", 32'(reg_idx), 32'd0);
    repeat (10) @(posedge clk);
    #1 chk("idle_no_toggle", 32'(sioc_edges), 32'd0);

    // Full run, with a start pulse injected during bit slot 5.
    push_tbl();
    pulse_start();
    chk("n1_busy", 32'(busy), 32'd1);
    chk("n1_siod", 32'(siod_o), 32'd1);
    @(posedge clk);
    #1;
    chk("n2_sioc", 32'(sioc), 32'd1);
    chk("n2_siod", 32'(siod_o), 32'd0);
    wait_bits(5, "reach_slot5");
    pulse_start();
    wait_done("run1_done");
    chk("run1_busy", 32'(busy), 32'd0);
    chk("run1_end_idx", 32'(reg_idx), 32'(END_IDX));
    chk("run1_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("run1_frames", 32'(frames_done), 32'(END_IDX - 1));
    chk("run1_stops", 32'(stops), 32'(END_IDX - 1));
`ifdef OV7670_TEST_PATTERN_EN
    chk("last_write", 32'(last_rv), 32'h71B5);
`else
    chk("last_write", 32'(last_rv), 32'h030A);
`endif
    repeat (20) @(posedge clk);
    #1;
    chk("done_held", 32'(done), 32'd1);
    chk("busy_held", 32'(busy), 32'd0);

    // Restart from done, then reset in the middle of the first write.
    push_tbl();
    pulse_start();
    chk("restart_done_clr", 32'(done), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    wait_bits(10, "reach_slot10");
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_sioc", 32'(sioc), 32'd1);
    chk("midrst_siod", 32'(siod_o), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();

    // Replay from index 0.
    push_tbl();
    pulse_start();
    chk("replay_idx", 32'(reg_idx), 32'd0);
    chk("replay_busy", 32'(busy), 32'd1);
    wait_done("run3_done");
    chk("run3_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("run3_end_idx", 32'(reg_idx), 32'(END_IDX));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
